// File: rtl/tlp_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// tlp_tx_arbiter_if
//   Bundles every stream and handshake signal around the TX arbiter:
//     req_*        NUM_REQ packed requester streams (requester i at slice i)
//     s_axis_tx_*  the single transmit stream towards the PCIe core
//     tx_cfg_*     core configuration-engine request/grant pair
//   Modports:
//     slave  - the arbiter's view (consumes req_*, produces s_axis_tx_*)
//     master - the environment's view (TLP sources + core model)
//
//   Handshake rule for every stream here: a beat transfers on a rising
//   clock edge where tvalid and tready are both high; a source holding
//   tvalid keeps its data stable until that edge, and tready may depend
//   combinationally on tvalid of the same stream.
// -----------------------------------------------------------------------------
interface tlp_tx_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DW      = 64
);
  logic [NUM_REQ*DW-1:0]   req_tdata;
  logic [NUM_REQ*DW/8-1:0] req_tkeep;
  logic [NUM_REQ-1:0]      req_tlast;
  logic [NUM_REQ*4-1:0]    req_tuser;
  logic [NUM_REQ-1:0]      req_tvalid;
  logic [NUM_REQ-1:0]      req_tready;

  logic [DW-1:0]           s_axis_tx_tdata;
  logic [DW/8-1:0]         s_axis_tx_tkeep;
  logic                    s_axis_tx_tlast;
  logic [3:0]              s_axis_tx_tuser;
  logic                    s_axis_tx_tvalid;
  logic                    s_axis_tx_tready;

  logic                    tx_cfg_req;
  logic                    tx_cfg_gnt;

  modport slave (
    input  req_tdata, req_tkeep, req_tlast, req_tuser, req_tvalid,
    output req_tready,
    output s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast,
           s_axis_tx_tuser, s_axis_tx_tvalid,
    input  s_axis_tx_tready,
    input  tx_cfg_req,
    output tx_cfg_gnt
  );

  modport master (
    output req_tdata, req_tkeep, req_tlast, req_tuser, req_tvalid,
    input  req_tready,
    input  s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast,
           s_axis_tx_tuser, s_axis_tx_tvalid,
    output s_axis_tx_tready,
    output tx_cfg_req,
    input  tx_cfg_gnt
  );
endinterface

// File: rtl/tlp_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tlp_tx_arbiter
//   Packet-atomic round-robin arbiter sharing the PCIe core's single TX
//   AXI-stream among NUM_REQ TLP sources. A granted requester owns the
//   channel until its tlast beat is accepted. The core's configuration
//   engine (tx_cfg_req/tx_cfg_gnt) is only let in between packets and
//   wins over every requester when both are waiting.
//
//   Ports:
//     user_clk      core user clock, all logic on its rising edge
//     user_reset_n  asynchronous active-low reset
//     bus           tlp_tx_arbiter_if.slave (requester streams, core stream,
//                   configuration request/grant)
//     grant         one-hot current owner, zero when nobody owns the channel
//     busy          high while a requester owns the channel
//     dbg_state     current FSM state (0 IDLE, 1 BUSY, 2 CFG)
// -----------------------------------------------------------------------------
module tlp_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DW      = 64
) (
  input  logic               user_clk,
  input  logic               user_reset_n,
  tlp_tx_arbiter_if.slave    bus,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int KW    = DW / 8;
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    CFG  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               cfg_gnt_q, cfg_gnt_d;
  logic [IDX_W-1:0]   rr_last_q, rr_last_d;

  logic [IDX_W-1:0]   owner_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;

  logic [DW-1:0]      tx_tdata;
  logic [KW-1:0]      tx_tkeep;
  logic               tx_tlast;
  logic [3:0]         tx_tuser;
  logic               tx_tvalid;
  logic [NUM_REQ-1:0] req_tready_c;
  logic               last_beat_done;

  // Owner index decoded from the one-hot grant register.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) owner_idx = IDX_W'(i);
    end
  end

  // Round-robin search: first valid requester starting just after the
  // previous owner, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_idx = IDX_W'((int'(rr_last_q) + off) % NUM_REQ);
      if (!pick_found && bus.req_tvalid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Zero-latency pass-through of the owner's stream; everything is forced
  // to zero outside BUSY so the core never sees a stray beat.
  always_comb begin
    tx_tdata     = '0;
    tx_tkeep     = '0;
    tx_tlast     = 1'b0;
    tx_tuser     = '0;
    tx_tvalid    = 1'b0;
    req_tready_c = '0;
    if (state_q == BUSY) begin
      tx_tdata                = bus.req_tdata[owner_idx*DW +: DW];
      tx_tkeep                = bus.req_tkeep[owner_idx*KW +: KW];
      tx_tlast                = bus.req_tlast[owner_idx];
      tx_tuser                = bus.req_tuser[owner_idx*4 +: 4];
      tx_tvalid               = bus.req_tvalid[owner_idx];
      req_tready_c[owner_idx] = bus.s_axis_tx_tready;
    end
  end

  assign last_beat_done = tx_tvalid && bus.s_axis_tx_tready && tx_tlast;

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cfg_gnt_d = cfg_gnt_q;
    rr_last_d = rr_last_q;
    unique case (state_q)
      IDLE: begin
        if (bus.tx_cfg_req) begin
          state_d   = CFG;
          cfg_gnt_d = 1'b1;
        end else if (pick_found) begin
          state_d  = BUSY;
          grant_d  = '0;
          grant_d[pick_idx] = 1'b1;
        end
      end
      BUSY: begin
        // Ownership ends only on the accepted tlast beat; source stalls,
        // core back-pressure and configuration requests all wait for it.
        if (last_beat_done) begin
          state_d   = IDLE;
          grant_d   = '0;
          rr_last_d = owner_idx;
        end
      end
      CFG: begin
        if (!bus.tx_cfg_req) begin
          state_d   = IDLE;
          cfg_gnt_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        grant_d   = '0;
        cfg_gnt_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      cfg_gnt_q <= 1'b0;
      rr_last_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cfg_gnt_q <= cfg_gnt_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign bus.s_axis_tx_tdata  = tx_tdata;
  assign bus.s_axis_tx_tkeep  = tx_tkeep;
  assign bus.s_axis_tx_tlast  = tx_tlast;
  assign bus.s_axis_tx_tuser  = tx_tuser;
  assign bus.s_axis_tx_tvalid = tx_tvalid;
  assign bus.req_tready       = req_tready_c;
  assign bus.tx_cfg_gnt       = cfg_gnt_q;

  assign grant     = grant_q;
  assign busy      = (state_q == BUSY);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tlp_tx_arbiter
//   Bench for tlp_tx_arbiter with NUM_REQ=2, DW=64. Source models hold
//   per-requester beat queues; every beat queued is also pushed, in the
//   order the arbiter must emit it, to exp_q and popped when the core
//   side accepts a beat. Per-cycle control/status expectations come from
//   a vector table; reset-mid-packet and single-beat throughput are
//   written out by hand.
// -----------------------------------------------------------------------------
module tb_tlp_tx_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DW      = 64;
  localparam int KW      = DW / 8;
  localparam int BW      = DW + KW + 1 + 4;

  // ---------------------------------------------------------------- clock/reset
  logic user_clk     = 1'b0;
  logic user_reset_n = 1'b0;
  always #5 user_clk = ~user_clk;

  logic [NUM_REQ-1:0] grant;
  logic               busy;
  logic [1:0]         dbg_state;

  tlp_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DW(DW)) bus ();

  tlp_tx_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW)) dut (
    .user_clk     (user_clk),
    .user_reset_n (user_reset_n),
    .bus          (bus),
    .grant        (grant),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------- state
  typedef struct {
    logic       cfg;
    logic       rdy;
    logic [1:0] grant;
    logic       busy;
    logic       cfg_gnt;
    logic       tvalid;
    logic [1:0] req_rdy;
  } vec_t;

  vec_t           vec_q[$];
  logic [BW-1:0]  exp_q[$];
  logic [BW-1:0]  src0_q[$];
  logic [BW-1:0]  src1_q[$];
  logic           hs0 = 1'b0;
  logic           hs1 = 1'b0;
  int             n_tests = 0;
  int             n_fail  = 0;
  int             pkt_cnt = 0;
  int             beats_seen = 0;

  // ---------------------------------------------------------------- scoreboard
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic add_vec(input logic cfg, input logic rdy, input logic [1:0] g,
                         input logic b, input logic cg, input logic tv, input logic [1:0] rr);
    vec_t v;
    v.cfg = cfg; v.rdy = rdy; v.grant = g; v.busy = b;
    v.cfg_gnt = cg; v.tvalid = tv; v.req_rdy = rr;
    vec_q.push_back(v);
  endtask

  // Beat layout: {tlast, tuser, tkeep, tdata}; tdata tags requester/packet/beat.
  task automatic add_pkt(input int id, input int nbeats, input logic [KW-1:0] last_keep);
    logic [BW-1:0] b;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [3:0]    u;
    logic          l;
    for (int i = 0; i < nbeats; i++) begin
      d = {8'(id), 8'(pkt_cnt), 16'(i), 32'($urandom())};
      l = (i == nbeats - 1);
      k = l ? last_keep : {KW{1'b1}};
      u = 4'($urandom_range(0, 15));
      b = {l, u, k, d};
      if (id == 0) src0_q.push_back(b);
      else         src1_q.push_back(b);
      exp_q.push_back(b);
    end
    pkt_cnt++;
  endtask

  task automatic drive_req(input int id, input logic vld, input logic [BW-1:0] b);
    bus.req_tvalid[id]           = vld;
    bus.req_tdata[id*DW +: DW]   = b[DW-1:0];
    bus.req_tkeep[id*KW +: KW]   = b[DW +: KW];
    bus.req_tuser[id*4 +: 4]     = b[DW+KW +: 4];
    bus.req_tlast[id]            = b[BW-1];
  endtask

  task automatic clear_inputs();
    bus.req_tdata        = '0;
    bus.req_tkeep        = '0;
    bus.req_tlast        = '0;
    bus.req_tuser        = '0;
    bus.req_tvalid       = '0;
    bus.tx_cfg_req       = 1'b0;
    bus.s_axis_tx_tready = 1'b0;
  endtask

  // One clock cycle: retire last cycle's handshakes, present queue heads,
  // then sample the combinational outputs well before the next rising edge.
  task automatic step(input logic cfg, input logic rdy);
    logic [BW-1:0] act;
    @(negedge user_clk);
    if (hs0 && src0_q.size() > 0) void'(src0_q.pop_front());
    if (hs1 && src1_q.size() > 0) void'(src1_q.pop_front());
    if (src0_q.size() > 0) drive_req(0, 1'b1, src0_q[0]);
    else                   drive_req(0, 1'b0, '0);
    if (src1_q.size() > 0) drive_req(1, 1'b1, src1_q[0]);
    else                   drive_req(1, 1'b0, '0);
    bus.tx_cfg_req       = cfg;
    bus.s_axis_tx_tready = rdy;
    #1;
    hs0 = bus.req_tvalid[0] & bus.req_tready[0];
    hs1 = bus.req_tvalid[1] & bus.req_tready[1];
    if (bus.s_axis_tx_tvalid && bus.s_axis_tx_tready) begin
      beats_seen++;
      act = {bus.s_axis_tx_tlast, bus.s_axis_tx_tuser, bus.s_axis_tx_tkeep, bus.s_axis_tx_tdata};
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL beat: got unexpected beat %0h, expected none", act);
      end else begin
        check("beat", 128'(act), 128'(exp_q.pop_front()));
      end
    end
    check("grant_onehot0", 128'($onehot0(grant)), 128'(1));
    check("cfg_busy_excl", 128'(!(busy && bus.tx_cfg_gnt)), 128'(1));
  endtask

  task automatic do_reset();
    @(negedge user_clk);
    user_reset_n = 1'b0;
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    hs0 = 1'b0;
    hs1 = 1'b0;
    clear_inputs();
    #1;
    check("rst_grant",   128'(grant), 128'(0));
    check("rst_busy",    128'(busy), 128'(0));
    check("rst_cfg_gnt", 128'(bus.tx_cfg_gnt), 128'(0));
    check("rst_tvalid",  128'(bus.s_axis_tx_tvalid), 128'(0));
    check("rst_req_rdy", 128'(bus.req_tready), 128'(0));
    check("rst_state",   128'(dbg_state), 128'(0));
    repeat (2) @(negedge user_clk);
    user_reset_n = 1'b1;
  endtask

  task automatic run_vec(input int lo, input int hi);
    logic [6:0] act;
    logic [6:0] exp;
    for (int i = lo; i < hi; i++) begin
      step(vec_q[i].cfg, vec_q[i].rdy);
      act = {grant, busy, bus.tx_cfg_gnt, bus.s_axis_tx_tvalid, bus.req_tready};
      exp = {vec_q[i].grant, vec_q[i].busy, vec_q[i].cfg_gnt, vec_q[i].tvalid, vec_q[i].req_rdy};
      check($sformatf("vec[%0d] {grant,busy,cfg_gnt,tvalid,req_rdy}", i), 128'(act), 128'(exp));
    end
  endtask

  task automatic check_drained(input string name);
    check(name, 128'(exp_q.size()), 128'(0));
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    int t1_lo, t1_hi, t2_lo, t2_hi, t3_lo, t3_hi, t4_lo, t4_hi;
    int g_exp;

    // Vector table: cfg, core rdy | grant, busy, cfg_gnt, tvalid, req_tready
    // 1: single 4-beat packet from requester 0
    t1_lo = vec_q.size();
    add_vec(0, 1, 2'b00, 0, 0, 0, 2'b00);
    for (int i = 0; i < 4; i++) add_vec(0, 1, 2'b01, 1, 0, 1, 2'b01);
    add_vec(0, 1, 2'b00, 0, 0, 0, 2'b00);
    add_vec(0, 1, 2'b00, 0, 0, 0, 2'b00);
    t1_hi = vec_q.size();
    // 2: both requesters streaming 2-beat packets -> 0,1,0,1 with bubbles
    t2_lo = vec_q.size();
    for (int p = 0; p < 4; p++) begin
      add_vec(0, 1, 2'b00, 0, 0, 0, 2'b00);
      add_vec(0, 1, (p % 2 == 0) ? 2'b01 : 2'b10, 1, 0, 1, (p % 2 == 0) ? 2'b01 : 2'b10);
      add_vec(0, 1, (p % 2 == 0) ? 2'b01 : 2'b10, 1, 0, 1, (p % 2 == 0) ? 2'b01 : 2'b10);
    end
    add_vec(0, 1, 2'b00, 0, 0, 0, 2'b00);
    t2_hi = vec_q.size();
    // 3: core back-pressure 1,0,0,1 during requester 1's 3-beat packet
    t3_lo = vec_q.size();
    add_vec(0, 1, 2'b00, 0, 0, 0, 2'b00);
    add_vec(0, 1, 2'b10, 1, 0, 1, 2'b10);
    add_vec(0, 0, 2'b10, 1, 0, 1, 2'b00);
    add_vec(0, 0, 2'b10, 1, 0, 1, 2'b00);
    add_vec(0, 1, 2'b10, 1, 0, 1, 2'b10);
    add_vec(0, 1, 2'b10, 1, 0, 1, 2'b10);
    add_vec(0, 1, 2'b00, 0, 0, 0, 2'b00);
    t3_hi = vec_q.size();
    // 4: configuration request arriving mid-packet of requester 0
    t4_lo = vec_q.size();
    add_vec(0, 1, 2'b00, 0, 0, 0, 2'b00);
    add_vec(0, 1, 2'b01, 1, 0, 1, 2'b01);
    add_vec(1, 1, 2'b01, 1, 0, 1, 2'b01);
    add_vec(1, 1, 2'b01, 1, 0, 1, 2'b01);
    add_vec(1, 1, 2'b00, 0, 0, 0, 2'b00);
    add_vec(1, 1, 2'b00, 0, 1, 0, 2'b00);
    add_vec(0, 1, 2'b00, 0, 1, 0, 2'b00);
    add_vec(0, 1, 2'b00, 0, 0, 0, 2'b00);
    add_vec(0, 1, 2'b10, 1, 0, 1, 2'b10);
    add_vec(0, 1, 2'b10, 1, 0, 1, 2'b10);
    add_vec(0, 1, 2'b00, 0, 0, 0, 2'b00);
    t4_hi = vec_q.size();

    clear_inputs();

    do_reset();
    add_pkt(0, 4, 8'h0F);
    run_vec(t1_lo, t1_hi);
    check_drained("t1_drained");

    do_reset();
    add_pkt(0, 2, 8'hFF);
    add_pkt(1, 2, 8'hFF);
    add_pkt(0, 2, 8'hFF);
    add_pkt(1, 2, 8'hFF);
    run_vec(t2_lo, t2_hi);
    check_drained("t2_drained");

    do_reset();
    add_pkt(1, 3, 8'h3F);
    run_vec(t3_lo, t3_hi);
    check_drained("t3_drained");

    do_reset();
    add_pkt(0, 3, 8'hFF);
    add_pkt(1, 2, 8'h01);
    run_vec(t4_lo, t4_hi);
    check_drained("t4_drained");

    // 5: asynchronous reset in the middle of requester 0's packet
    do_reset();
    add_pkt(0, 4, 8'hFF);
    add_pkt(1, 4, 8'hFF);
    step(0, 1);
    step(0, 1);
    step(0, 1);
    check("t5_pre_grant", 128'(grant), 128'(2'b01));
    #1;
    user_reset_n = 1'b0;
    #1;
    check("t5_rst_tvalid", 128'(bus.s_axis_tx_tvalid), 128'(0));
    check("t5_rst_grant",  128'(grant), 128'(0));
    check("t5_rst_busy",   128'(busy), 128'(0));
    check("t5_rst_rdy",    128'(bus.req_tready), 128'(0));
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    hs0 = 1'b0;
    hs1 = 1'b0;
    clear_inputs();
    repeat (2) @(negedge user_clk);
    user_reset_n = 1'b1;
    add_pkt(0, 2, 8'hFF);
    add_pkt(1, 2, 8'hFF);
    step(0, 1);
    step(0, 1);
    check("t5_first_grant", 128'(grant), 128'(2'b01));
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(0, 1);
    check_drained("t5_drained");

    // 6: back-to-back single-beat packets from requester 1
    do_reset();
    for (int i = 0; i < 3; i++) add_pkt(1, 1, 8'hFF);
    beats_seen = 0;
    for (int c = 0; c < 7; c++) begin
      step(0, 1);
      g_exp = (c % 2 == 1) ? 2 : 0;
      check($sformatf("t6_grant[%0d]", c), 128'(grant), 128'(g_exp));
    end
    check("t6_beats_in_7_cycles", 128'(beats_seen), 128'(3));
    check_drained("t6_drained");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
